// File: rtl/sao_pkg.sv
// rtl/sao_pkg.sv - shared stage states and component indices for the SAO CTU sequencer
package sao_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        RUN   = 2'd1,
        DONE  = 2'd2
    } stage_st_t;

    localparam logic [1:0] CIDX_Y  = 2'd0;
    localparam logic [1:0] CIDX_CB = 2'd1;
    localparam logic [1:0] CIDX_CR = 2'd2;

endpackage

// File: rtl/sao_stage_slot.sv
// rtl/sao_stage_slot.sv - one pipeline stage holding a CTU token with start/done tracking
module sao_stage_slot
    import sao_pkg::*;
#(
    parameter int X_LEN = 9,
    parameter int Y_LEN = 9
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [X_LEN-1:0] load_x_i,
    input  logic [Y_LEN-1:0] load_y_i,
    input  logic             finish_i,
    input  logic             restart_i,
    input  logic             leave_i,
    output logic             empty_o,
    output logic             run_o,
    output logic             done_o,
    output logic             start_o,
    output logic [X_LEN-1:0] x_o,
    output logic [Y_LEN-1:0] y_o
);

    stage_st_t        st_q, st_d;
    logic             start_q, start_d;
    logic [X_LEN-1:0] x_q, x_d;
    logic [Y_LEN-1:0] y_q, y_d;

    // A load always wins over a leave so a stage refilled in its vacating cycle stays busy.
    always_comb begin
        st_d    = st_q;
        start_d = start_q;
        x_d     = x_q;
        y_d     = y_q;
        if (!rst_n) begin
            st_d    = EMPTY;
            start_d = 1'b0;
            x_d     = '0;
            y_d     = '0;
        end else if (en_i) begin
            start_d = 1'b0;
            if (load_i) begin
                st_d    = RUN;
                start_d = 1'b1;
                x_d     = load_x_i;
                y_d     = load_y_i;
            end else if (leave_i) begin
                st_d = EMPTY;
            end else if (st_q == RUN && finish_i) begin
                st_d = DONE;
            end else if (st_q == RUN && restart_i) begin
                start_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            st_q    <= EMPTY;
            start_q <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            st_q    <= st_d;
            start_q <= start_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    // A start held over a frozen cycle is still issued once enable returns.
    assign start_o = start_q && en_i;
    assign empty_o = (st_q == EMPTY);
    assign run_o   = (st_q == RUN);
    assign done_o  = (st_q == DONE);
    assign x_o     = x_q;
    assign y_o     = y_q;

endmodule

// File: rtl/sao_ctu_seq.sv
// rtl/sao_ctu_seq.sv - moves CTU tokens through SAO stat, decision and filter stages
module sao_ctu_seq
    import sao_pkg::*;
#(
    parameter int CUT_X_LEN = 9,
    parameter int CUT_Y_LEN = 9,
    parameter bit CHROMA_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 arst_n,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [CUT_X_LEN-1:0] pic_w_ctb,
    input  logic [CUT_Y_LEN-1:0] pic_h_ctb,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CUT_X_LEN-1:0] in_ctu_x,
    input  logic [CUT_Y_LEN-1:0] in_ctu_y,
    output logic                 stat_start,
    output logic [1:0]           stat_cidx,
    input  logic                 stat_done,
    output logic                 deci_start,
    input  logic                 deci_done,
    output logic                 filt_start,
    input  logic                 filt_done,
    output logic [CUT_X_LEN-1:0] stat_ctu_x,
    output logic [CUT_Y_LEN-1:0] stat_ctu_y,
    output logic [CUT_X_LEN-1:0] deci_ctu_x,
    output logic [CUT_Y_LEN-1:0] deci_ctu_y,
    output logic [CUT_X_LEN-1:0] filt_ctu_x,
    output logic [CUT_Y_LEN-1:0] filt_ctu_y,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 err
);

    logic       stat_empty, stat_run, stat_fin;
    logic       deci_empty, deci_run, deci_fin;
    logic       filt_empty, filt_run, filt_fin;
    logic       accept, stat_adv, deci_adv, filt_retire, stat_last;
    logic [1:0] cidx_q, cidx_d;
    logic       err_q, err_d;

    assign stat_last   = !CHROMA_EN || (cidx_q == CIDX_CR);
    assign in_ready    = en && stat_empty;
    assign accept      = in_valid && in_ready;
    assign filt_retire = en && rst_n && filt_fin;
    assign deci_adv    = en && deci_fin && (filt_empty || filt_retire);
    // Stat never refills in the cycle it advances: accept needs it EMPTY, advance needs it DONE.
    assign stat_adv    = en && stat_fin && (deci_empty || deci_adv);

    sao_stage_slot #(.X_LEN(CUT_X_LEN), .Y_LEN(CUT_Y_LEN)) u_stat (
        .clk(clk), .arst_n(arst_n), .rst_n(rst_n), .en_i(en),
        .load_i(accept), .load_x_i(in_ctu_x), .load_y_i(in_ctu_y),
        .finish_i(stat_done && stat_last), .restart_i(stat_done && !stat_last),
        .leave_i(stat_adv),
        .empty_o(stat_empty), .run_o(stat_run), .done_o(stat_fin),
        .start_o(stat_start), .x_o(stat_ctu_x), .y_o(stat_ctu_y)
    );

    sao_stage_slot #(.X_LEN(CUT_X_LEN), .Y_LEN(CUT_Y_LEN)) u_deci (
        .clk(clk), .arst_n(arst_n), .rst_n(rst_n), .en_i(en),
        .load_i(stat_adv), .load_x_i(stat_ctu_x), .load_y_i(stat_ctu_y),
        .finish_i(deci_done), .restart_i(1'b0), .leave_i(deci_adv),
        .empty_o(deci_empty), .run_o(deci_run), .done_o(deci_fin),
        .start_o(deci_start), .x_o(deci_ctu_x), .y_o(deci_ctu_y)
    );

    sao_stage_slot #(.X_LEN(CUT_X_LEN), .Y_LEN(CUT_Y_LEN)) u_filt (
        .clk(clk), .arst_n(arst_n), .rst_n(rst_n), .en_i(en),
        .load_i(deci_adv), .load_x_i(deci_ctu_x), .load_y_i(deci_ctu_y),
        .finish_i(filt_done), .restart_i(1'b0), .leave_i(filt_retire),
        .empty_o(filt_empty), .run_o(filt_run), .done_o(filt_fin),
        .start_o(filt_start), .x_o(filt_ctu_x), .y_o(filt_ctu_y)
    );

    always_comb begin
        cidx_d = cidx_q;
        err_d  = err_q;
        if (!rst_n) begin
            cidx_d = CIDX_Y;
            err_d  = 1'b0;
        end else if (en) begin
            if (accept) begin
                cidx_d = CIDX_Y;
            end else if (stat_run && stat_done && !stat_last) begin
                cidx_d = cidx_q + 2'd1;
            end
            if ((stat_done && !stat_run) || (deci_done && !deci_run) ||
                (filt_done && !filt_run)) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cidx_q <= CIDX_Y;
            err_q  <= 1'b0;
        end else begin
            cidx_q <= cidx_d;
            err_q  <= err_d;
        end
    end

    assign stat_cidx  = cidx_q;
    assign err        = err_q;
    assign busy       = !(stat_empty && deci_empty && filt_empty);
    assign frame_done = filt_retire && (filt_ctu_x == pic_w_ctb) && (filt_ctu_y == pic_h_ctb);

endmodule

// File: tb/tb_sao_ctu_seq.sv
// tb/tb_sao_ctu_seq.sv - scoreboard bench for the SAO CTU sequencer
module tb_sao_ctu_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       arst_n, rst_n, en;
    logic [8:0] pic_w, pic_h, in_x, in_y;
    logic       in_valid, stat_done, deci_done, filt_done;
    logic       in_ready, stat_start, deci_start, filt_start, busy, frame_done, err;
    logic [1:0] stat_cidx;
    logic [8:0] sx, sy, dx, dy, fx, fy;

    logic       l_in_valid, l_stat_done, l_zero;
    logic       l_in_ready, l_stat_start, l_deci_start, l_filt_start, l_busy, l_frame_done, l_err;
    logic [1:0] l_cidx;
    logic [8:0] l_sx, l_sy, l_dx, l_dy, l_fx, l_fy;

    sao_ctu_seq #(.CUT_X_LEN(9), .CUT_Y_LEN(9), .CHROMA_EN(1'b1)) dut (
        .clk(clk), .arst_n(arst_n), .rst_n(rst_n), .en(en),
        .pic_w_ctb(pic_w), .pic_h_ctb(pic_h),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctu_x(in_x), .in_ctu_y(in_y),
        .stat_start(stat_start), .stat_cidx(stat_cidx), .stat_done(stat_done),
        .deci_start(deci_start), .deci_done(deci_done),
        .filt_start(filt_start), .filt_done(filt_done),
        .stat_ctu_x(sx), .stat_ctu_y(sy), .deci_ctu_x(dx), .deci_ctu_y(dy),
        .filt_ctu_x(fx), .filt_ctu_y(fy),
        .busy(busy), .frame_done(frame_done), .err(err)
    );

    sao_ctu_seq #(.CUT_X_LEN(9), .CUT_Y_LEN(9), .CHROMA_EN(1'b0)) dut_luma (
        .clk(clk), .arst_n(arst_n), .rst_n(rst_n), .en(en),
        .pic_w_ctb(pic_w), .pic_h_ctb(pic_h),
        .in_valid(l_in_valid), .in_ready(l_in_ready), .in_ctu_x(in_x), .in_ctu_y(in_y),
        .stat_start(l_stat_start), .stat_cidx(l_cidx), .stat_done(l_stat_done),
        .deci_start(l_deci_start), .deci_done(l_zero),
        .filt_start(l_filt_start), .filt_done(l_zero),
        .stat_ctu_x(l_sx), .stat_ctu_y(l_sy), .deci_ctu_x(l_dx), .deci_ctu_y(l_dy),
        .filt_ctu_x(l_fx), .filt_ctu_y(l_fy),
        .busy(l_busy), .frame_done(l_frame_done), .err(l_err)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference: every accepted CTU owes three stat runs (Y, Cb, Cr), one decision and one
    // filter, each in arrival order; a frame pulse is owed for each CTU at the picture corner.
    logic [19:0] sq[$], dq[$], fq[$];
    logic [19:0] e_mon;
    int exp_frames, got_frames;

    always @(negedge clk) begin
        if (!arst_n || !rst_n) begin
            sq.delete(); dq.delete(); fq.delete();
        end else begin
            if (stat_start) begin
                if (sq.size() == 0) chk("stat_unexpected", 64'd1, 64'd0);
                else begin e_mon = sq.pop_front(); chk("stat_token", 64'({stat_cidx, sy, sx}), 64'(e_mon)); end
            end
            if (deci_start) begin
                if (dq.size() == 0) chk("deci_unexpected", 64'd1, 64'd0);
                else begin e_mon = dq.pop_front(); chk("deci_token", 64'({2'd0, dy, dx}), 64'(e_mon)); end
            end
            if (filt_start) begin
                if (fq.size() == 0) chk("filt_unexpected", 64'd1, 64'd0);
                else begin e_mon = fq.pop_front(); chk("filt_token", 64'({2'd0, fy, fx}), 64'(e_mon)); end
            end
            if (frame_done) got_frames++;
            if (in_valid && in_ready) begin
                for (int k = 0; k < 3; k++) sq.push_back({2'(k), in_y, in_x});
                dq.push_back({2'd0, in_y, in_x});
                fq.push_back({2'd0, in_y, in_x});
                if (in_x == pic_w && in_y == pic_h) exp_frames++;
            end
        end
    end

    int  pend[3], cnt[3];
    int  rmax, starts_seen, ready_seen;
    bit  blk_filt, will_acc;
    logic [2:0] stv, dn;

    task automatic clear_resp();
        for (int k = 0; k < 3; k++) begin pend[k] = 0; cnt[k] = 0; end
        stat_done = 0; deci_done = 0; filt_done = 0; will_acc = 0;
    endtask

    task automatic do_reset();
        arst_n = 0; rst_n = 1; en = 1; in_valid = 0; l_in_valid = 0; l_stat_done = 0;
        l_zero = 0; blk_filt = 0; in_x = 0; in_y = 0;
        clear_resp();
        repeat (2) @(posedge clk);
        #1 arst_n = 1;
    endtask

    // vmode: 0 idle upstream, 1 always valid, 2 random valid; done responders reply after 0..rmax cycles
    task automatic run(input int n, input int vmode);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (!in_valid || will_acc) begin
                in_valid = (vmode == 1) || (vmode == 2 && $urandom_range(0, 1) == 1);
                in_x = 9'($urandom_range(0, 3));
                in_y = 9'($urandom_range(0, 3));
            end
            if (vmode == 0) in_valid = 0;
            #1;
            will_acc = in_valid && in_ready;
            if (in_ready) ready_seen++;
            stv = {filt_start, deci_start, stat_start};
            if (|stv) starts_seen++;
            for (int k = 0; k < 3; k++) begin
                if (stv[k]) begin pend[k] = 1; cnt[k] = $urandom_range(0, rmax); end
                dn[k] = (pend[k] == 1) && (cnt[k] == 0) && !(k == 2 && blk_filt);
                if (en) begin
                    if (dn[k]) pend[k] = 0;
                    else if (pend[k] == 1 && cnt[k] > 0) cnt[k]--;
                end
            end
            stat_done = dn[0]; deci_done = dn[1]; filt_done = dn[2];
        end
    endtask

    logic [63:0] snap;

    initial begin
        pic_w = 0; pic_h = 0; rmax = 0; exp_frames = 0; got_frames = 0;
        do_reset();

        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_starts", 64'({stat_start, deci_start, filt_start, frame_done, err}), 64'd0);
        chk("rst_cidx", 64'(stat_cidx), 64'd0);
        chk("rst_coords", 64'({sx, sy, dx, dy, fx, fy}), 64'd0);

        // single CTU timeline, handshake in cycle 1
        for (int c = 1; c <= 27; c++) begin
            in_valid  = (c == 1);
            stat_done = (c == 5 || c == 8 || c == 11);
            deci_done = (c == 20);
            filt_done = (c == 25);
            #1;
            if (c == 1) chk("t_in_ready", 64'(in_ready), 64'd1);
            chk("t_stat_start", 64'(stat_start), 64'(c == 2 || c == 6 || c == 9));
            if (stat_start) chk("t_cidx", 64'(stat_cidx), (c == 2) ? 64'd0 : (c == 6) ? 64'd1 : 64'd2);
            chk("t_deci_start", 64'(deci_start), 64'(c == 13));
            chk("t_filt_start", 64'(filt_start), 64'(c == 22));
            chk("t_frame_done", 64'(frame_done), 64'(c == 26));
            chk("t_busy", 64'(busy), 64'(c >= 2 && c <= 26));
            @(posedge clk); #1;
        end
        clear_resp(); in_valid = 0;

        // luma-only instance: one stat run then straight to decision
        do_reset();
        in_x = 9'd5; in_y = 9'd6; l_in_valid = 1;
        @(posedge clk); #1;
        l_in_valid = 0;
        chk("l_stat_start", 64'(l_stat_start), 64'd1);
        chk("l_cidx", 64'(l_cidx), 64'd0);
        l_stat_done = 1;
        @(posedge clk); #1;
        l_stat_done = 0;
        chk("l_no_restart", 64'(l_stat_start), 64'd0);
        @(posedge clk); #1;
        chk("l_deci_start", 64'(l_deci_start), 64'd1);
        chk("l_deci_coord", 64'({l_dx, l_dy}), 64'({9'd5, 9'd6}));
        chk("l_stat_quiet", 64'(l_stat_start), 64'd0);

        // randomized traffic with random response latency
        do_reset();
        pic_w = 9'($urandom_range(0, 3)); pic_h = 9'($urandom_range(0, 3));
        exp_frames = 0; got_frames = 0; rmax = 3;
        run(600, 2);
        run(150, 0);
        chk("rand_drained", 64'(busy), 64'd0);
        chk("rand_queues", 64'(sq.size() + dq.size() + fq.size()), 64'd0);
        chk("rand_frames", 64'(got_frames), 64'(exp_frames));
        chk("rand_err", 64'(err), 64'd0);

        // back-to-back with instant done pulses
        exp_frames = 0; got_frames = 0; rmax = 0;
        run(200, 1);
        run(60, 0);
        chk("b2b_queues", 64'(sq.size() + dq.size() + fq.size()), 64'd0);
        chk("b2b_frames", 64'(got_frames), 64'(exp_frames));

        // filter backpressure for 50 cycles
        blk_filt = 1;
        run(60, 1);
        starts_seen = 0; ready_seen = 0;
        run(50, 1);
        chk("bp_no_starts", 64'(starts_seen), 64'd0);
        chk("bp_no_ready", 64'(ready_seen), 64'd0);
        chk("bp_busy", 64'(busy), 64'd1);
        blk_filt = 0; starts_seen = 0;
        run(5, 1);
        chk("bp_resume", 64'(starts_seen > 0), 64'd1);
        run(80, 0);
        chk("bp_drained", 64'(busy), 64'd0);

        // enable freeze mid-run
        rmax = 2;
        run(20, 1);
        en = 0;
        snap = 64'({sx, sy, dx, dy, fx, fy, stat_cidx, busy});
        starts_seen = 0; ready_seen = 0;
        run(10, 1);
        chk("en_no_starts", 64'(starts_seen), 64'd0);
        chk("en_no_ready", 64'(ready_seen), 64'd0);
        chk("en_frozen", 64'({sx, sy, dx, dy, fx, fy, stat_cidx, busy}), snap);
        en = 1;
        run(120, 0);
        chk("en_drained", 64'(busy), 64'd0);
        chk("en_queues", 64'(sq.size() + dq.size() + fq.size()), 64'd0);

        // synchronous clear with the pipeline full
        rmax = 3;
        run(40, 1);
        rst_n = 0; in_valid = 0; clear_resp();
        #1 chk("srst_no_frame", 64'(frame_done), 64'd0);
        @(posedge clk); #1;
        rst_n = 1;
        chk("srst_busy", 64'(busy), 64'd0);
        chk("srst_ready", 64'(in_ready), 64'd1);
        chk("srst_quiet", 64'({stat_start, deci_start, filt_start, frame_done}), 64'd0);
        chk("srst_cidx", 64'(stat_cidx), 64'd0);

        // spurious decision done with the decision stage empty
        deci_done = 1;
        @(posedge clk); #1;
        deci_done = 0;
        chk("err_set", 64'(err), 64'd1);
        chk("err_no_state", 64'({busy, in_ready}), 64'({1'b0, 1'b1}));
        repeat (3) @(posedge clk);
        #1 chk("err_sticky", 64'(err), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
